key_debounce_n: RTL and testbench

KEY_DEBOUNCE_N -- requirements
Module: key_debounce_n

---
 rtl/key_debounce_n_pkg.sv | 22 ++
 rtl/key_debounce_n_ch.sv | 177 +++++++++++++++++
 rtl/key_debounce_n.sv | 74 +++++++
 tb/tb_key_debounce_n.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/key_debounce_n_pkg.sv
// Shared types and sizing helpers for the key debouncer.
package key_debounce_n_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRESS_DB  = 3'd1,
    ST_HELD      = 3'd2,
    ST_LONG_HELD = 3'd3,
    ST_REL_DB    = 3'd4
  } key_state_e;

  localparam int DB_CNT_W = 8;

  function automatic int ms_divisor(input int clk_hz);
    return clk_hz / 1000;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_debounce_n_ch.sv
// One key channel: two-flop synchronizer, debounce/hold FSM and its counters.
// Hold and repeat counters keep running through a release debounce so a short glitch keeps the cadence.
module key_debounce_ch
  import key_debounce_n_pkg::*;
#(
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000,
  parameter int REPEAT_MS   = 200,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_tick,
  input  logic i_raw,
  output logic o_level,
  output logic o_level_nxt,
  output logic o_press,
  output logic o_release,
  output logic o_long,
  output logic o_repeat
);
  localparam int HOLD_W = cnt_width(LONG_MS + 1);
  localparam int REP_W  = cnt_width(REPEAT_MS + 1);
  localparam logic [DB_CNT_W-1:0] DB_LAST  = DB_CNT_W'(DEBOUNCE_MS - 1);
  localparam logic [HOLD_W-1:0]   HOLD_MAX = HOLD_W'(LONG_MS);
  localparam logic [REP_W-1:0]    REP_MAX  = REP_W'(REPEAT_MS);
  localparam logic                RAW_IDLE = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  key_state_e          r_state, w_state_nxt;
  logic                r_sync1, r_sync2, w_key;
  logic                r_back_long, w_back_nxt;
  logic [DB_CNT_W-1:0] r_db, w_db_nxt;
  logic [HOLD_W-1:0]   r_hold, w_hold_nxt, w_hold_inc;
  logic [REP_W-1:0]    r_rep, w_rep_nxt, w_rep_inc;
  logic                r_level, r_press, r_release, r_long, r_repeat;
  logic                w_level_nxt, w_press, w_release, w_long, w_repeat;

  assign w_key      = r_sync2 ^ RAW_IDLE;
  assign w_hold_inc = (r_hold == HOLD_MAX) ? r_hold : r_hold + HOLD_W'(1);
  assign w_rep_inc  = (r_rep == REP_MAX) ? r_rep : r_rep + REP_W'(1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= RAW_IDLE;
      r_sync2 <= RAW_IDLE;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_back_nxt  = r_back_long;
    w_db_nxt    = r_db;
    w_hold_nxt  = r_hold;
    w_rep_nxt   = r_rep;
    w_level_nxt = r_level;
    w_press     = 1'b0;
    w_release   = 1'b0;
    w_long      = 1'b0;
    w_repeat    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_key) begin
          w_state_nxt = ST_PRESS_DB;
          w_db_nxt    = '0;
        end else begin
          w_db_nxt    = '0;
        end
      end
      ST_PRESS_DB: begin
        if (!w_key) begin
          w_state_nxt = ST_IDLE;
          w_db_nxt    = '0;
        end else if (i_tick && (r_db == DB_LAST)) begin
          w_state_nxt = ST_HELD;
          w_db_nxt    = '0;
          w_hold_nxt  = '0;
          w_rep_nxt   = '0;
          w_level_nxt = 1'b1;
          w_press     = 1'b1;
        end else if (i_tick) begin
          w_db_nxt    = r_db + DB_CNT_W'(1);
        end else begin
          w_db_nxt    = r_db;
        end
      end
      ST_HELD: begin
        w_hold_nxt = i_tick ? w_hold_inc : r_hold;
        if (!w_key) begin
          w_state_nxt = ST_REL_DB;
          w_back_nxt  = 1'b0;
          w_db_nxt    = '0;
        end else if (i_tick && (w_hold_inc == HOLD_MAX)) begin
          w_state_nxt = ST_LONG_HELD;
          w_rep_nxt   = '0;
          w_long      = 1'b1;
        end else begin
          w_state_nxt = ST_HELD;
        end
      end
      ST_LONG_HELD: begin
        w_hold_nxt = i_tick ? w_hold_inc : r_hold;
        w_rep_nxt  = i_tick ? w_rep_inc : r_rep;
        if (!w_key) begin
          w_state_nxt = ST_REL_DB;
          w_back_nxt  = 1'b1;
          w_db_nxt    = '0;
        end else if (i_tick && (w_rep_inc == REP_MAX)) begin
          w_rep_nxt   = '0;
          w_repeat    = 1'b1;
        end else begin
          w_state_nxt = ST_LONG_HELD;
        end
      end
      ST_REL_DB: begin
        w_hold_nxt = i_tick ? w_hold_inc : r_hold;
        w_rep_nxt  = (i_tick && r_back_long) ? w_rep_inc : r_rep;
        if (w_key) begin
          w_state_nxt = r_back_long ? ST_LONG_HELD : ST_HELD;
          w_db_nxt    = '0;
        end else if (i_tick && (r_db == DB_LAST)) begin
          w_state_nxt = ST_IDLE;
          w_back_nxt  = 1'b0;
          w_db_nxt    = '0;
          w_hold_nxt  = '0;
          w_rep_nxt   = '0;
          w_level_nxt = 1'b0;
          w_release   = 1'b1;
        end else if (i_tick) begin
          w_db_nxt    = r_db + DB_CNT_W'(1);
        end else begin
          w_db_nxt    = r_db;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_db_nxt    = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_back_long <= 1'b0;
      r_db        <= '0;
      r_hold      <= '0;
      r_rep       <= '0;
      r_level     <= 1'b0;
      r_press     <= 1'b0;
      r_release   <= 1'b0;
      r_long      <= 1'b0;
      r_repeat    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_back_long <= w_back_nxt;
      r_db        <= w_db_nxt;
      r_hold      <= w_hold_nxt;
      r_rep       <= w_rep_nxt;
      r_level     <= w_level_nxt;
      r_press     <= w_press;
      r_release   <= w_release;
      r_long      <= w_long;
      r_repeat    <= w_repeat;
    end
  end

  assign o_level     = r_level;
  assign o_level_nxt = w_level_nxt;
  assign o_press     = r_press;
  assign o_release   = r_release;
  assign o_long      = r_long;
  assign o_repeat    = r_repeat;

endmodule

// File: rtl/key_debounce_n.sv
// Multi-key debouncer: shared 1 ms prescaler plus one key_debounce_ch per key.
module key_debounce_n
  import key_debounce_n_pkg::*;
#(
  parameter int N_KEYS      = 4,
  parameter int CLK_HZ      = 50_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000,
  parameter int REPEAT_MS   = 200,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic              CLK_50,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_raw,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long,
  output logic [N_KEYS-1:0] key_repeat,
  output logic              key_any
);
  localparam int DIV     = ms_divisor(CLK_HZ);
  localparam int PRESC_W = cnt_width(DIV);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DIV - 1);

  logic [PRESC_W-1:0] r_presc;
  logic               w_ms_tick;
  logic [N_KEYS-1:0]  w_level_nxt;
  logic               r_any;

  assign w_ms_tick = (r_presc == PRESC_LAST);

  always_ff @(posedge CLK_50) begin
    if (rst) begin
      r_presc <= '0;
    end else if (w_ms_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PRESC_W'(1);
    end
  end

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_MS (DEBOUNCE_MS),
      .LONG_MS     (LONG_MS),
      .REPEAT_MS   (REPEAT_MS),
      .ACTIVE_LOW  (ACTIVE_LOW)
    ) u_ch (
      .i_clk       (CLK_50),
      .i_rst       (rst),
      .i_tick      (w_ms_tick),
      .i_raw       (key_raw[g]),
      .o_level     (key_level[g]),
      .o_level_nxt (w_level_nxt[g]),
      .o_press     (key_press[g]),
      .o_release   (key_release[g]),
      .o_long      (key_long[g]),
      .o_repeat    (key_repeat[g])
    );
  end

  // key_any is registered from the channels' next levels so it lines up with key_level.
  always_ff @(posedge CLK_50) begin
    if (rst) begin
      r_any <= 1'b0;
    end else begin
      r_any <= |w_level_nxt;
    end
  end

  assign key_any = r_any;

endmodule

// File: tb/tb_key_debounce_n.sv
// Directed bench for key_debounce_n with a cycle-level behavioural model and literal timing checks.
module tb_key_debounce_n;
  localparam int N   = 4;
  localparam int DIV = 10;
  localparam int DB  = 3;
  localparam int LG  = 10;
  localparam int RP  = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] key_raw = '1;
  logic [N-1:0] key_level, key_press, key_release, key_long, key_repeat;
  logic         key_any;

  always #5 clk = ~clk;

  key_debounce_n #(
    .N_KEYS(N), .CLK_HZ(10_000), .DEBOUNCE_MS(DB), .LONG_MS(LG), .REPEAT_MS(RP), .ACTIVE_LOW(1)
  ) dut (
    .CLK_50(clk), .rst(rst), .key_raw(key_raw), .key_level(key_level), .key_press(key_press),
    .key_release(key_release), .key_long(key_long), .key_repeat(key_repeat), .key_any(key_any)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic set_keys(input logic [N-1:0] pressed);
    key_raw = ~pressed;
  endtask

  // Model: a level flips once the opposite reading has lasted DB ticks; long/repeat follow ticks since accept.
  logic [N-1:0] e_level = '0, e_press = '0, e_release = '0, e_long = '0, e_repeat = '0;
  logic         e_any = 1'b0;

  initial begin : model
    logic [N-1:0] s1, s2, kp;
    int pc;
    bit tick, k;
    int opp[N], age[N], lage[N];
    bit lvl[N], ldone[N];
    s1 = '0; s2 = '0; kp = '0; pc = 0;
    for (int c = 0; c < N; c++) begin
      opp[c] = 0; age[c] = 0; lage[c] = 0; lvl[c] = 1'b0; ldone[c] = 1'b0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      e_press = '0; e_release = '0; e_long = '0; e_repeat = '0;
      if (rst) begin
        s1 = '0; s2 = '0; kp = '0; pc = 0;
        for (int c = 0; c < N; c++) begin
          opp[c] = 0; age[c] = 0; lage[c] = 0; lvl[c] = 1'b0; ldone[c] = 1'b0;
        end
        e_level = '0;
        e_any = 1'b0;
      end else begin
        tick = (pc == DIV - 1);
        for (int c = 0; c < N; c++) begin
          k = s2[c];
          if (lvl[c] && tick) age[c]++;
          if (k != lvl[c]) begin
            if (k == kp[c] && tick) opp[c]++;
            if (opp[c] == DB) begin
              opp[c] = 0; lvl[c] = k; age[c] = 0;
              if (k) e_press[c] = 1'b1;
              else begin e_release[c] = 1'b1; ldone[c] = 1'b0; end
            end
          end else begin
            opp[c] = 0;
          end
          if (lvl[c] && k && kp[c] && tick) begin
            if (!ldone[c] && age[c] >= LG) begin
              e_long[c] = 1'b1; ldone[c] = 1'b1; lage[c] = age[c];
            end else if (ldone[c] && age[c] > lage[c] && ((age[c] - lage[c]) % RP) == 0) begin
              e_repeat[c] = 1'b1;
            end
          end
          e_level[c] = lvl[c];
        end
        e_any = |e_level;
        kp = s2; s2 = s1; s1 = ~key_raw;
        pc = tick ? 0 : pc + 1;
      end
    end
  end

  int n_press[N] = '{default: 0};
  int n_rel[N]   = '{default: 0};
  int n_long[N]  = '{default: 0};
  int n_rep[N]   = '{default: 0};
  int n_hi[N]    = '{default: 0};
  int t_press[N] = '{default: 0};
  int t_long[N]  = '{default: 0};
  int t_rep1[N]  = '{default: 0};
  int t_rep2[N]  = '{default: 0};
  int rep_idx[N] = '{default: 0};
  int n_1001 = 0;

  initial begin : compare
    forever begin
      @(negedge clk);
      chk("key_level",   32'(key_level),   32'(e_level));
      chk("key_press",   32'(key_press),   32'(e_press));
      chk("key_release", 32'(key_release), 32'(e_release));
      chk("key_long",    32'(key_long),    32'(e_long));
      chk("key_repeat",  32'(key_repeat),  32'(e_repeat));
      chk("key_any",     32'(key_any),     32'(e_any));
      for (int c = 0; c < N; c++) begin
        if (key_press[c] === 1'b1)   begin n_press[c]++; t_press[c] = cyc; end
        if (key_release[c] === 1'b1) n_rel[c]++;
        if (key_long[c] === 1'b1)    begin n_long[c]++; t_long[c] = cyc; rep_idx[c] = 0; end
        if (key_repeat[c] === 1'b1) begin
          if (rep_idx[c] == 0) t_rep1[c] = cyc;
          else if (rep_idx[c] == 1) t_rep2[c] = cyc;
          rep_idx[c]++;
          n_rep[c]++;
        end
        if (key_level[c] === 1'b1) n_hi[c]++;
      end
      if (key_press === 4'b1001) n_1001++;
    end
  end

  initial begin : stim
    int sp, sr, sl, sq, sh, c0;
    bit seen;
    set_keys('0);
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({key_level, key_press, key_release, key_long, key_repeat, key_any}), 32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // Scenario 1: clean 6 ms press on key0.
    sp = n_press[0]; sr = n_rel[0]; sl = n_long[0]; sh = n_hi[0];
    set_keys(4'b0001); repeat (60) @(negedge clk);
    set_keys(4'b0000); repeat (80) @(negedge clk);
    chk("s1_press_cnt", n_press[0] - sp, 1);
    chk("s1_release_cnt", n_rel[0] - sr, 1);
    chk("s1_long_cnt", n_long[0] - sl, 0);
    chk("s1_level_cycles", n_hi[0] - sh, 60);

    // Scenario 2: key1 bouncing at 1 ms.
    sp = n_press[1]; sr = n_rel[1]; sh = n_hi[1];
    for (int i = 0; i < 5; i++) begin
      set_keys(4'b0010); repeat (10) @(negedge clk);
      set_keys(4'b0000); repeat (10) @(negedge clk);
    end
    repeat (40) @(negedge clk);
    chk("s2_press_cnt", n_press[1] - sp, 0);
    chk("s2_release_cnt", n_rel[1] - sr, 0);
    chk("s2_level_cycles", n_hi[1] - sh, 0);

    // Scenario 3: key2 held long enough for long press and two repeats.
    sp = n_press[2]; sr = n_rel[2]; sl = n_long[2]; sq = n_rep[2];
    set_keys(4'b0100); repeat (220) @(negedge clk);
    set_keys(4'b0000); repeat (60) @(negedge clk);
    chk("s3_press_cnt", n_press[2] - sp, 1);
    chk("s3_long_cnt", n_long[2] - sl, 1);
    chk("s3_repeat_cnt", n_rep[2] - sq, 2);
    chk("s3_release_cnt", n_rel[2] - sr, 1);
    chk("s3_long_delay", t_long[2] - t_press[2], 100);
    chk("s3_rep1_delay", t_rep1[2] - t_long[2], 40);
    chk("s3_rep2_delay", t_rep2[2] - t_long[2], 80);

    // Scenario 4: key0 and key3 pressed together.
    sp = n_1001;
    set_keys(4'b1001); repeat (40) @(negedge clk);
    chk("s4_press_1001", n_1001 - sp, 1);
    set_keys(4'b0000); repeat (60) @(negedge clk);

    // Scenario 5: reset pulse while key2 is held.
    set_keys(4'b0100); repeat (150) @(negedge clk);
    sr = n_rel[2];
    rst = 1'b1;
    @(negedge clk);
    chk("s5_reset_out_1", 32'({key_level, key_press, key_release, key_long, key_repeat, key_any}), 32'd0);
    @(negedge clk);
    chk("s5_reset_out_2", 32'({key_level, key_press, key_release, key_long, key_repeat, key_any}), 32'd0);
    rst = 1'b0;
    c0 = cyc; sp = n_press[2];
    repeat (40) @(negedge clk);
    chk("s5_press_cnt", n_press[2] - sp, 1);
    chk("s5_press_delay", t_press[2] - c0, 30);
    chk("s5_no_release", n_rel[2] - sr, 0);
    set_keys(4'b0000); repeat (60) @(negedge clk);

    // Scenario 6: 1 ms release glitch on key3 during the long-held phase.
    set_keys(4'b1000);
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (key_long[3] === 1'b1) begin seen = 1'b1; break; end
    end
    chk("s6_long_seen", 32'(seen), 32'd1);
    repeat (10) @(negedge clk);
    sr = n_rel[3];
    set_keys(4'b0000); repeat (10) @(negedge clk);
    set_keys(4'b1000); repeat (100) @(negedge clk);
    chk("s6_no_release", n_rel[3] - sr, 0);
    chk("s6_rep1_delay", t_rep1[3] - t_long[3], 40);
    chk("s6_rep2_delay", t_rep2[3] - t_long[3], 80);
    set_keys(4'b0000); repeat (60) @(negedge clk);
    chk("s6_release_after", n_rel[3] - sr, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
